// File: rtl/phys_free_list_pkg.sv
// Shared types and sizing for the physical-register free list.
// Optional duplicate-release checking is enabled with FREELIST_DUP_CHECK_EN.
package phys_free_list_pkg;

  localparam int PROJ_LOG_PHYS      = 6;
  localparam int PROJ_NUM_ARCH_REGS = 32;

  localparam int LOG_PHYS = PROJ_LOG_PHYS;
  localparam int NUM_PHYS = 1 << LOG_PHYS;
  localparam int NUM_ARCH = PROJ_NUM_ARCH_REGS;
  localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);

  typedef logic [LOG_PHYS-1:0] phys_reg_t;
  typedef logic [PTR_W-1:0]    fl_ptr_t;
  typedef logic [CNT_W-1:0]    fl_cnt_t;

  typedef struct packed {
    logic underflow;
    logic overflow;
    logic dup;
  } fl_err_t;

  // Explicit compare against DEPTH-1 keeps non-power-of-2 depths legal.
  function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
    return (p == fl_ptr_t'(DEPTH - 1)) ? '0 : fl_ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/phys_free_list_ptr.sv
// Wrapping circular-buffer pointer with increment enable and parallel load.
// Load takes priority over increment; reset returns the pointer to slot 0.
module freelist_ptr
  import phys_free_list_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [PTR_W-1:0]   load_val_i,
  output logic [PTR_W-1:0]   ptr_o
);

  fl_ptr_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_inc(ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices with a committed head for one-cycle flush recovery.
// Define FREELIST_DUP_CHECK_EN to drop and flag releases of registers already on the list.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Grabbed_regs,
  output logic [LOG_PHYS-1:0] Free_phys_reg,
  output logic                Free_reg_avail,
  input  logic                Retire_alloc_IN,
  input  logic                Release_valid_IN,
  input  logic [LOG_PHYS-1:0] Release_reg_IN,
  input  logic                Flush_IN,
  output logic [CNT_W-1:0]    Count_OUT,
  output logic                Underflow_err,
  output logic                Overflow_err,
  output logic                Dup_err
);

  phys_reg_t mem_q [DEPTH];
  fl_ptr_t   head, commit_head, commit_head_d, tail;
  fl_cnt_t   count_q, count_d, commit_count_q, commit_count_d;
  fl_err_t   err_q, err_d;
  logic      pop_ok, push_legal, push_ok, retire_ok, dup_hit;

  assign pop_ok     = Grabbed_regs && (count_q != '0) && !Flush_IN;
  assign retire_ok  = Retire_alloc_IN && (commit_count_q != '0);
  assign push_legal = Release_valid_IN && (Release_reg_IN != '0) &&
                      (commit_count_q != fl_cnt_t'(DEPTH));
  assign push_ok    = push_legal && !dup_hit;

  // Flush must see the commit head after this cycle's retire advance.
  assign commit_head_d = retire_ok ? ptr_inc(commit_head) : commit_head;

  freelist_ptr u_head (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .inc_i      (pop_ok),
    .load_i     (Flush_IN),
    .load_val_i (commit_head_d),
    .ptr_o      (head)
  );

  freelist_ptr u_commit_head (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .inc_i      (retire_ok),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (commit_head)
  );

  freelist_ptr u_tail (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .inc_i      (push_ok),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (tail)
  );

  always_comb begin
    commit_count_d = commit_count_q + fl_cnt_t'(push_ok) - fl_cnt_t'(retire_ok);
    count_d        = count_q + fl_cnt_t'(push_ok) - fl_cnt_t'(pop_ok);
    if (Flush_IN) begin
      count_d = commit_count_d;
    end
    err_d           = '0;
    err_d.underflow = (Grabbed_regs && !Flush_IN && (count_q == '0)) ||
                      (Retire_alloc_IN && (commit_count_q == '0));
    err_d.overflow  = Release_valid_IN &&
                      ((Release_reg_IN == '0) || (commit_count_q == fl_cnt_t'(DEPTH)));
    err_d.dup       = dup_hit;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q        <= fl_cnt_t'(DEPTH);
      commit_count_q <= fl_cnt_t'(DEPTH);
      err_q          <= '0;
    end else begin
      count_q        <= count_d;
      commit_count_q <= commit_count_d;
      err_q          <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= phys_reg_t'(NUM_ARCH + i);
      end
    end else if (push_ok) begin
      mem_q[tail] <= Release_reg_IN;
    end
  end

`ifdef FREELIST_DUP_CHECK_EN
  localparam logic [NUM_PHYS-1:0] IN_LIST_RST = {{DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};

  logic [NUM_PHYS-1:0] in_list_q, in_list_d, commit_in_list_q, commit_in_list_d;

  assign dup_hit = push_legal && in_list_q[Release_reg_IN];

  // The committed vector tracks commit_head..tail; the speculative one tracks head..tail.
  always_comb begin
    commit_in_list_d = commit_in_list_q;
    in_list_d        = in_list_q;
    if (retire_ok) commit_in_list_d[mem_q[commit_head]] = 1'b0;
    if (push_ok)   commit_in_list_d[Release_reg_IN] = 1'b1;
    if (pop_ok)    in_list_d[Free_phys_reg] = 1'b0;
    if (push_ok)   in_list_d[Release_reg_IN] = 1'b1;
    if (Flush_IN)  in_list_d = commit_in_list_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_list_q        <= IN_LIST_RST;
      commit_in_list_q <= IN_LIST_RST;
    end else begin
      in_list_q        <= in_list_d;
      commit_in_list_q <= commit_in_list_d;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  assign Free_phys_reg  = mem_q[head];
  assign Free_reg_avail = (count_q != '0);
  assign Count_OUT      = count_q;
  assign Underflow_err  = err_q.underflow;
  assign Overflow_err   = err_q.overflow;
  assign Dup_err        = err_q.dup;

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios plus random traffic against a queue-based model.
// The model holds the committed list as a queue plus a count of speculative pops past its front.
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic          CLK = 1'b0;
  logic          RESET, Grabbed_regs, Retire_alloc_IN, Release_valid_IN, Flush_IN;
  logic [5:0]    Release_reg_IN;
  logic [5:0]    Free_phys_reg;
  logic          Free_reg_avail;
  logic [5:0]    Count_OUT;
  logic          Underflow_err, Overflow_err, Dup_err;

  phys_free_list dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .Grabbed_regs     (Grabbed_regs),
    .Free_phys_reg    (Free_phys_reg),
    .Free_reg_avail   (Free_reg_avail),
    .Retire_alloc_IN  (Retire_alloc_IN),
    .Release_valid_IN (Release_valid_IN),
    .Release_reg_IN   (Release_reg_IN),
    .Flush_IN         (Flush_IN),
    .Count_OUT        (Count_OUT),
    .Underflow_err    (Underflow_err),
    .Overflow_err     (Overflow_err),
    .Dup_err          (Dup_err)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: committed free list in order, and how many entries Rename has taken speculatively.
  logic [5:0] exp_q[$];
  int         spec_pops;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    return exp_q.size() - spec_pops;
  endfunction

  function automatic bit in_spec(input logic [5:0] r);
    for (int i = spec_pops; i < exp_q.size(); i++) begin
      if (exp_q[i] == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic do_reset(input bit with_traffic);
    RESET            = 1'b1;
    Flush_IN         = with_traffic;
    Grabbed_regs     = with_traffic;
    Retire_alloc_IN  = 1'b0;
    Release_valid_IN = with_traffic;
    Release_reg_IN   = 6'd9;
    @(posedge CLK); #1;
    RESET            = 1'b0;
    Flush_IN         = 1'b0;
    Grabbed_regs     = 1'b0;
    Release_valid_IN = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(6'(NUM_ARCH + i));
    spec_pops = 0;
    check("rst_count", Count_OUT, 32);
    check("rst_avail", Free_reg_avail, 1);
    check("rst_free_reg", Free_phys_reg, 32);
    check("rst_underflow", Underflow_err, 0);
    check("rst_overflow", Overflow_err, 0);
    check("rst_dup", Dup_err, 0);
  endtask

  // One clock: drive, check combinational outputs, step model, check registered outputs.
  task automatic cycle(input bit grab, input bit ret, input bit rel,
                       input logic [5:0] rreg, input bit fl);
    int  cnt;
    bit  e_under, e_over, e_dup, do_pop, do_push, do_ret;
    Grabbed_regs     = grab;
    Retire_alloc_IN  = ret;
    Release_valid_IN = rel;
    Release_reg_IN   = rreg;
    Flush_IN         = fl;
    #1;
    cnt = m_count();
    check("avail", Free_reg_avail, (cnt != 0));
    if (cnt != 0) check("free_reg", Free_phys_reg, exp_q[spec_pops]);
    e_under = (grab && !fl && cnt == 0) || (ret && exp_q.size() == 0);
    e_over  = rel && (rreg == 0 || exp_q.size() == DEPTH);
`ifdef FREELIST_DUP_CHECK_EN
    e_dup   = rel && !e_over && in_spec(rreg);
`else
    e_dup   = 1'b0;
`endif
    do_pop  = grab && !fl && cnt != 0;
    do_push = rel && !e_over && !e_dup;
    do_ret  = ret && exp_q.size() != 0;
    if (do_pop) spec_pops++;
    if (do_ret) begin
      void'(exp_q.pop_front());
      spec_pops--;
    end
    if (do_push) exp_q.push_back(rreg);
    if (fl) spec_pops = 0;
    @(posedge CLK); #1;
    check("count", Count_OUT, m_count());
    check("underflow", Underflow_err, e_under);
    check("overflow", Overflow_err, e_over);
    check("dup", Dup_err, e_dup);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 6'd0, 0);
  endtask

  initial begin
    do_reset(0);

    // Drain all 32, then underflow; retire everything so pushes are legal.
    for (int i = 0; i < 32; i++) cycle(1, 0, 0, 6'd0, 0);
    check("drained_avail", Free_reg_avail, 0);
    check("drained_count", Count_OUT, 0);
    cycle(1, 0, 0, 6'd0, 0);
    for (int i = 0; i < 32; i++) cycle(0, 1, 0, 6'd0, 0);
    cycle(1, 0, 1, 6'd5, 0);
    check("push5_free_reg", Free_phys_reg, 5);
    cycle(1, 0, 0, 6'd0, 0);
    check("push5_pop_count", Count_OUT, 0);

    // Simultaneous pop and push, then drain until the pushed 7 appears.
    do_reset(0);
    cycle(1, 0, 0, 6'd0, 0);
    cycle(0, 1, 0, 6'd0, 0);
    cycle(1, 0, 1, 6'd7, 0);
    check("poppush_count", Count_OUT, 31);
    for (int i = 0; i < 30; i++) cycle(1, 0, 0, 6'd0, 0);
    check("wrapped_free_reg", Free_phys_reg, 7);
    cycle(1, 0, 0, 6'd0, 0);

    // Pop 4, retire 2, flush.
    do_reset(0);
    repeat (4) cycle(1, 0, 0, 6'd0, 0);
    repeat (2) cycle(0, 1, 0, 6'd0, 0);
    cycle(0, 0, 0, 6'd0, 1);
    check("flush_free_reg", Free_phys_reg, 34);
    check("flush_count", Count_OUT, 30);

    // Flush with pop and retire in the same cycle.
    do_reset(0);
    repeat (3) cycle(1, 0, 0, 6'd0, 0);
    cycle(1, 1, 0, 6'd0, 1);
    check("flush_pop_ret_free_reg", Free_phys_reg, 33);
    check("flush_pop_ret_count", Count_OUT, 31);

    // Overflow cases and duplicate release.
    do_reset(0);
    cycle(0, 0, 1, 6'd40, 0);
    cycle(0, 0, 1, 6'd0, 0);
    cycle(1, 0, 0, 6'd0, 0);
    cycle(0, 1, 0, 6'd0, 0);
    cycle(0, 0, 1, 6'd40, 0);
    idle();

    // Reset overrides a flush/pop/push in the same cycle.
    cycle(1, 0, 0, 6'd0, 0);
    do_reset(1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      bit         g, r, v, f;
      logic [5:0] rr;
      if (n % 200 == 199) do_reset($urandom_range(0, 1));
      g  = ($urandom_range(0, 99) < 45);
      r  = ((spec_pops > 0) || (exp_q.size() == 0)) && ($urandom_range(0, 99) < 40);
      v  = ($urandom_range(0, 99) < 40);
      rr = ($urandom_range(0, 99) < 5) ? 6'd0 : 6'($urandom_range(1, 63));
      f  = ($urandom_range(0, 99) < 5);
      cycle(g, r, v, rr, f);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
